// File: rtl/sequenciador_pkg.sv
// sequenciador_pkg: shared state encoding, command types and opcode width for the RPN sequencer.
package sequenciador_pkg;

    localparam int OP_W = 3;

    localparam logic CMD_PUSH_SW = 1'b0;
    localparam logic CMD_OPERA   = 1'b1;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        EMPILHA_SW  = 3'd1,
        VERIFICA    = 3'd2,
        INICIA_ULA  = 3'd3,
        ESPERA_ULA  = 3'd4,
        EMPILHA_RES = 3'd5
    } estado_t;

endpackage

// File: rtl/fifo_comandos.sv
// fifo_comandos: registered command FIFO; depth must be a power of two so the pointers wrap freely.
module fifo_comandos #(
    parameter int PROF = 2,
    parameter int LARG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [LARG-1:0] din,
    input  logic            pop,
    output logic [LARG-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(PROF);
    localparam logic [AW:0] CHEIO = (AW + 1)'(PROF);

    logic [LARG-1:0] mem [PROF];
    logic [AW-1:0]   wr, rd;
    logic [AW:0]     cnt;
    logic            ok_push, ok_pop;

    assign ok_push = push & ~full;
    assign ok_pop  = pop & ~empty;
    assign full    = cnt == CHEIO;
    assign empty   = cnt == '0;
    assign dout    = mem[rd];

    always_ff @(posedge clk)
        if (ok_push) mem[wr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (ok_push) wr <= wr + 1'b1;
            if (ok_pop) rd <= rd + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, ok_push} - {{AW{1'b0}}, ok_pop};
        end

endmodule

// File: rtl/sequenciador_rpn.sv
// sequenciador_rpn: queues key commands and sequences stack pushes and ULA runs,
// rejecting operations without two operands and aborting a ULA that never answers.
module sequenciador_rpn
    import sequenciador_pkg::*;
#(
    parameter int PROF_PILHA     = 4,
    parameter int PROF_FIFO      = 2,
    parameter int TIMEOUT_CICLOS = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_tipo,
    input  logic [OP_W-1:0]                 cmd_op,
    output logic                            pilha_empilha,
    output logic                            pilha_sel_sw,
    output logic                            ula_inicia,
    output logic [OP_W-1:0]                 ula_op_code,
    input  logic                            ula_pronto,
    output logic                            flags_carrega,
    output logic                            ocupado,
    output logic                            erro_underflow,
    output logic                            erro_timeout,
    output logic [$clog2(PROF_PILHA+1)-1:0] profundidade
);

    localparam int PW = $clog2(PROF_PILHA + 1);
    localparam int WW = $clog2(TIMEOUT_CICLOS);
    localparam logic [PW-1:0] PROF_MAX = PW'(PROF_PILHA);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CICLOS - 1);

    estado_t       estado, prox;
    logic [OP_W:0] cabeca;
    logic          vazia, cheia, retira, poucos, expirou;
    logic [WW-1:0] watchdog;

    fifo_comandos #(.PROF(PROF_FIFO), .LARG(OP_W + 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid & cmd_ready),
        .din   ({cmd_tipo, cmd_op}),
        .pop   (retira),
        .dout  (cabeca),
        .full  (cheia),
        .empty (vazia)
    );

    assign cmd_ready      = rst_n & ~cheia;
    assign poucos         = profundidade < PW'(2);
    assign expirou        = watchdog == WD_MAX;
    assign pilha_empilha  = estado == EMPILHA_SW || estado == EMPILHA_RES;
    assign pilha_sel_sw   = estado == EMPILHA_SW;
    assign ula_inicia     = estado == INICIA_ULA;
    assign flags_carrega  = estado == EMPILHA_RES;
    assign erro_underflow = estado == VERIFICA && poucos;
    // pronto on the expiry cycle wins, so the abort pulse is qualified by it
    assign erro_timeout   = estado == ESPERA_ULA && expirou && !ula_pronto;
    assign ocupado        = estado != OCIOSO || !vazia;

    always_comb begin
        prox   = estado;
        retira = 1'b0;
        case (estado)
            OCIOSO: if (!vazia) begin
                retira = 1'b1;
                prox   = cabeca[OP_W] == CMD_PUSH_SW ? EMPILHA_SW : VERIFICA;
            end
            VERIFICA:   prox = poucos ? OCIOSO : INICIA_ULA;
            INICIA_ULA: prox = ESPERA_ULA;
            ESPERA_ULA: prox = ula_pronto ? EMPILHA_RES : expirou ? OCIOSO : ESPERA_ULA;
            default:    prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado       <= OCIOSO;
            ula_op_code  <= '0;
            profundidade <= '0;
            watchdog     <= '0;
        end else begin
            estado <= prox;
            if (retira && cabeca[OP_W] == CMD_OPERA) ula_op_code <= cabeca[OP_W-1:0];
            // a full stack drops its oldest entry, so occupancy just stops climbing
            if (estado == EMPILHA_SW && profundidade != PROF_MAX) profundidade <= profundidade + 1'b1;
            else if (estado == EMPILHA_RES) profundidade <= profundidade - 1'b1;
            if (estado == INICIA_ULA) watchdog <= '0;
            else if (estado == ESPERA_ULA) watchdog <= watchdog + 1'b1;
        end

endmodule

// File: tb/tb_sequenciador_rpn.sv
// tb_sequenciador_rpn: directed scenario bench for the RPN command sequencer.
module tb_sequenciador_rpn;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_tipo = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       pilha_empilha, pilha_sel_sw, ula_inicia, flags_carrega;
    logic [2:0] ula_op_code;
    logic       ula_pronto = 1'b0;
    logic       ocupado, erro_underflow, erro_timeout;
    logic [2:0] profundidade;

    int total = 0;
    int bad = 0;

    sequenciador_rpn dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_tipo       (cmd_tipo),
        .cmd_op         (cmd_op),
        .pilha_empilha  (pilha_empilha),
        .pilha_sel_sw   (pilha_sel_sw),
        .ula_inicia     (ula_inicia),
        .ula_op_code    (ula_op_code),
        .ula_pronto     (ula_pronto),
        .flags_carrega  (flags_carrega),
        .ocupado        (ocupado),
        .erro_underflow (erro_underflow),
        .erro_timeout   (erro_timeout),
        .profundidade   (profundidade)
    );

    always #5 clk = ~clk;

    // event recorder: strobe counts, cycle stamps and occupancy history
    int cyc = 0, n_sw = 0, n_res = 0, n_ini = 0, n_und = 0, n_tmo = 0, n_ovl = 0;
    int t_ini = 0, t_res = 0, t_tmo = 0;
    int prof_q[$];
    logic [2:0] prof_ant = 3'd0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prof_ant <= profundidade;
        if (profundidade != prof_ant) prof_q.push_back(int'(profundidade));
        if (pilha_empilha && pilha_sel_sw) n_sw <= n_sw + 1;
        if (pilha_empilha && !pilha_sel_sw && flags_carrega) begin
            n_res <= n_res + 1;
            t_res <= cyc;
        end
        if (ula_inicia) begin
            n_ini <= n_ini + 1;
            t_ini <= cyc;
        end
        if (erro_underflow) n_und <= n_und + 1;
        if (erro_timeout) begin
            n_tmo <= n_tmo + 1;
            t_tmo <= cyc;
        end
        if (int'(pilha_empilha) + int'(ula_inicia) + int'(erro_underflow) + int'(erro_timeout) > 1 ||
            (flags_carrega && !(pilha_empilha && !pilha_sel_sw)))
            n_ovl <= n_ovl + 1;
    end

    task automatic apply_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        ula_pronto = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic tipo, input logic [2:0] op);
        int g = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_tipo = tipo;
        cmd_op = op;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (g >= 100) begin
            total++;
            bad++;
            $display("FAIL send_cmd: cmd_ready stayed 0 for %0d cycles", g);
        end
    endtask

    task automatic wait_idle(input int budget);
        int g = 0;
        @(negedge clk);
        while (ocupado && g < budget) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        #1;
        if (g >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_idle: ocupado still 1 after %0d cycles", g);
        end
    endtask

    task automatic wait_inicia();
        int g = 0;
        while (!ula_inicia && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            total++;
            bad++;
            $display("FAIL wait_inicia: ula_inicia never seen");
        end
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        #2 rst_n = 1'b0;
        #1;
        obs = {pilha_empilha, pilha_sel_sw, ula_inicia, flags_carrega, ocupado, erro_underflow,
               erro_timeout, cmd_ready, ula_op_code, profundidade};
        total++;
        if (obs !== 14'd0) begin bad++; $display("FAIL reset_outputs: got %b want all zero", obs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        total++;
        if ({ocupado, profundidade, ula_op_code} !== 7'd0)
            begin bad++; $display("FAIL reset_idle: ocupado=%b prof=%0d op=%0d want 0", ocupado, profundidade, ula_op_code); end
    endtask

    task automatic test_reset_mid_op();
        logic [13:0] obs;
        int sw0;
        apply_reset();
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b1, 3'd2);
        wait_inicia();
        repeat (3) @(negedge clk);
        send_cmd(1'b0, 3'd0);
        #2 rst_n = 1'b0;
        #1;
        obs = {pilha_empilha, pilha_sel_sw, ula_inicia, flags_carrega, ocupado, erro_underflow,
               erro_timeout, cmd_ready, ula_op_code, profundidade};
        total++;
        if (obs !== 14'd0) begin bad++; $display("FAIL midop_reset_outputs: got %b want all zero", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        sw0 = n_sw;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (ocupado !== 1'b0) begin bad++; $display("FAIL midop_fifo_flushed: ocupado=%b want 0", ocupado); end
        total++;
        if (profundidade !== 3'd0) begin bad++; $display("FAIL midop_prof: got %0d want 0", profundidade); end
        total++;
        if (n_sw - sw0 !== 0) begin bad++; $display("FAIL midop_no_push: got %0d pushes want 0", n_sw - sw0); end
    endtask

    task automatic test_push_op();
        int sw0, res0, ini0, ovl0, q0;
        apply_reset();
        sw0 = n_sw; res0 = n_res; ini0 = n_ini; ovl0 = n_ovl; q0 = prof_q.size();
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b1, 3'b000);
        wait_inicia();
        repeat (3) @(negedge clk);
        ula_pronto = 1'b1;
        @(negedge clk);
        ula_pronto = 1'b0;
        wait_idle(50);
        total++;
        if (n_sw - sw0 !== 2) begin bad++; $display("FAIL op_sw_pushes: got %0d want 2", n_sw - sw0); end
        total++;
        if (n_ini - ini0 !== 1) begin bad++; $display("FAIL op_inicia: got %0d want 1", n_ini - ini0); end
        total++;
        if (n_res - res0 !== 1) begin bad++; $display("FAIL op_result_push: got %0d want 1", n_res - res0); end
        total++;
        if (t_res - t_ini !== 4) begin bad++; $display("FAIL op_latency: got %0d cycles want 4", t_res - t_ini); end
        total++;
        if (prof_q.size() - q0 !== 3 || prof_q[q0] !== 1 || prof_q[q0+1] !== 2 || prof_q[q0+2] !== 1)
            begin bad++; $display("FAIL op_prof_seq: %0d changes, final prof=%0d want 1,2,1", prof_q.size() - q0, profundidade); end
        total++;
        if (n_ovl - ovl0 !== 0) begin bad++; $display("FAIL op_overlap: got %0d want 0", n_ovl - ovl0); end
    endtask

    task automatic test_underflow();
        int und0, ini0, q0;
        apply_reset();
        und0 = n_und; ini0 = n_ini; q0 = prof_q.size();
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b1, 3'd1);
        wait_idle(50);
        total++;
        if (n_und - und0 !== 1) begin bad++; $display("FAIL uf_pulse: got %0d want 1", n_und - und0); end
        total++;
        if (n_ini - ini0 !== 0) begin bad++; $display("FAIL uf_no_inicia: got %0d want 0", n_ini - ini0); end
        total++;
        if (profundidade !== 3'd1 || prof_q.size() - q0 !== 1)
            begin bad++; $display("FAIL uf_prof: got %0d (%0d changes) want 1", profundidade, prof_q.size() - q0); end
    endtask

    task automatic test_timeout();
        int tmo0, res0, sw0;
        apply_reset();
        tmo0 = n_tmo; res0 = n_res; sw0 = n_sw;
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b1, 3'b101);
        wait_idle(200);
        total++;
        if (n_tmo - tmo0 !== 1) begin bad++; $display("FAIL to_pulse: got %0d want 1", n_tmo - tmo0); end
        total++;
        if (t_tmo - t_ini !== 64) begin bad++; $display("FAIL to_delay: got %0d cycles want 64", t_tmo - t_ini); end
        total++;
        if (n_res - res0 !== 0 || n_sw - sw0 !== 2)
            begin bad++; $display("FAIL to_pushes: res=%0d sw=%0d want 0 and 2", n_res - res0, n_sw - sw0); end
        total++;
        if (profundidade !== 3'd2) begin bad++; $display("FAIL to_prof: got %0d want 2", profundidade); end
        total++;
        if (ula_op_code !== 3'b101) begin bad++; $display("FAIL to_opcode: got %0d want 5", ula_op_code); end
    endtask

    task automatic test_back_to_back();
        int sw0, q0, sent, stall, g;
        apply_reset();
        sw0 = n_sw; q0 = prof_q.size();
        sent = 0; stall = 0; g = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_tipo = 1'b0;
        cmd_op = 3'd0;
        while (sent < 5 && g < 60) begin
            if (cmd_ready) sent++;
            else stall++;
            @(negedge clk);
            g++;
        end
        cmd_valid = 1'b0;
        wait_idle(50);
        total++;
        if (sent !== 5) begin bad++; $display("FAIL b2b_sent: got %0d want 5", sent); end
        total++;
        if (stall < 1) begin bad++; $display("FAIL b2b_ready_drop: stalled %0d cycles want >0", stall); end
        total++;
        if (n_sw - sw0 !== 5) begin bad++; $display("FAIL b2b_pushes: got %0d want 5", n_sw - sw0); end
        total++;
        if (profundidade !== 3'd4 || prof_q.size() - q0 !== 4 || prof_q[q0+3] !== 4)
            begin bad++; $display("FAIL b2b_saturate: got %0d (%0d changes) want 4", profundidade, prof_q.size() - q0); end
    endtask

    task automatic test_stray_pronto();
        int res0, ini0, ovl0;
        logic [2:0] op_seen;
        apply_reset();
        send_cmd(1'b0, 3'd0);
        send_cmd(1'b0, 3'd0);
        wait_idle(50);
        res0 = n_res; ini0 = n_ini; ovl0 = n_ovl;
        ula_pronto = 1'b1;
        repeat (2) @(negedge clk);
        ula_pronto = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (n_res - res0 !== 0 || ocupado !== 1'b0)
            begin bad++; $display("FAIL stray_ignored: res=%0d ocupado=%b want 0 0", n_res - res0, ocupado); end
        send_cmd(1'b1, 3'b110);
        wait_inicia();
        op_seen = ula_op_code;
        @(negedge clk);
        ula_pronto = 1'b1;
        @(negedge clk);
        ula_pronto = 1'b0;
        wait_idle(50);
        total++;
        if (op_seen !== 3'b110) begin bad++; $display("FAIL stray_opcode: got %0d want 6", op_seen); end
        total++;
        if (n_res - res0 !== 1 || n_ini - ini0 !== 1)
            begin bad++; $display("FAIL stray_op_done: res=%0d ini=%0d want 1 1", n_res - res0, n_ini - ini0); end
        total++;
        if (t_res - t_ini !== 2) begin bad++; $display("FAIL stray_latency: got %0d want 2", t_res - t_ini); end
        total++;
        if (profundidade !== 3'd1 || n_ovl - ovl0 !== 0)
            begin bad++; $display("FAIL stray_prof: prof=%0d overlaps=%0d want 1 0", profundidade, n_ovl - ovl0); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_push_op();
        test_underflow();
        test_timeout();
        test_back_to_back();
        test_stray_pronto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
